// File: rtl/cpu_timer_irq_pkg.sv
// Shared definitions for the dual 16-bit interval timer: register map, CTRL/ICR bit positions, reset value.
// No logic; latency and backpressure do not apply.
// Imported by the timer unit, the top level and the bench.
package cpu_timer_irq_pkg;

    localparam logic [15:0] RESET_LATCH_DEFAULT = 16'hFFFF;
    localparam int          NUM_REGS            = 8;

    typedef enum logic [2:0] {
        REG_TA_LO  = 3'd0,
        REG_TA_HI  = 3'd1,
        REG_TB_LO  = 3'd2,
        REG_TB_HI  = 3'd3,
        REG_CTRL_A = 3'd4,
        REG_CTRL_B = 3'd5,
        REG_ICR    = 3'd6,
        REG_NONE   = 3'd7
    } reg_idx_t;

    localparam int CTRL_START      = 0;
    localparam int CTRL_ONESHOT    = 1;
    localparam int CTRL_FORCE_LOAD = 4;
    localparam int CTRL_CASCADE    = 5;
    localparam int CTRL_NMI_ROUTE  = 6;

    localparam int ICR_FLAG_A  = 0;
    localparam int ICR_FLAG_B  = 1;
    localparam int ICR_SET     = 7;
    localparam int ICR_PENDING = 7;

    function automatic logic [7:0] icr_pack(input logic pending, input logic [1:0] flags);
        logic [7:0] v;
        v              = 8'h00;
        v[ICR_PENDING] = pending;
        v[ICR_FLAG_B]  = flags[1];
        v[ICR_FLAG_A]  = flags[0];
        return v;
    endfunction

endpackage

// File: rtl/cpu_timer_irq_if.sv
// CPU-side register bus of the timer block (chip select, index, write strobe, ready, data both ways).
// Read data is combinational from the index; side effects only on ready=1.
// The CPU cannot be stalled by this block; ready comes from the shared bus.
interface cpu_timer_irq_if;
    logic       timer_cs;
    logic [3:0] timer_addr;
    logic [7:0] timer_data_i;
    logic [7:0] timer_data_o;
    logic       cpu_write;
    logic       ready;

    modport master (
        output timer_cs, timer_addr, timer_data_i, cpu_write, ready,
        input  timer_data_o
    );

    modport slave (
        input  timer_cs, timer_addr, timer_data_i, cpu_write, ready,
        output timer_data_o
    );
endinterface

// File: rtl/cpu_timer_irq_timer16_unit.sv
// One 16-bit down-counter with reload latch and control register.
// Underflow output is combinational in the step cycle so a cascaded timer steps in the same cycle.
// No backpressure: writes and steps are accepted every cycle they are presented.
module cpu_timer_irq_timer16_unit
    import cpu_timer_irq_pkg::*;
#(
    parameter logic [15:0] RESET_LATCH = RESET_LATCH_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_ctrl,
    input  logic [7:0]  wr_data,
    input  logic        step,
    output logic [15:0] count,
    output logic [7:0]  ctrl,
    output logic        underflow
);

    localparam logic [7:0] CTRL_STORE_MASK = ~(8'h01 << CTRL_FORCE_LOAD);

    logic [15:0] latch;
    logic        force_load;
    logic        run_step;

    // A forced load replaces the step entirely, so it also masks the underflow event.
    assign force_load = wr_ctrl & wr_data[CTRL_FORCE_LOAD];
    assign run_step   = ctrl[CTRL_START] & step & ~force_load;
    assign underflow  = run_step & (count == 16'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            latch <= RESET_LATCH;
            count <= RESET_LATCH;
            ctrl  <= 8'h00;
        end else begin
            if (wr_lo) latch[7:0]  <= wr_data;
            if (wr_hi) latch[15:8] <= wr_data;

            if (force_load)
                count <= latch;
            else if (wr_hi && !ctrl[CTRL_START])
                count <= {wr_data, latch[7:0]};
            else if (run_step)
                count <= underflow ? latch : count - 16'd1;

            if (wr_ctrl)
                ctrl <= wr_data & CTRL_STORE_MASK;
            else if (underflow && ctrl[CTRL_ONESHOT])
                ctrl[CTRL_START] <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_timer_irq.sv
// Dual 16-bit interval timer with interrupt control register, feeding cpu4510 irq/nmi.
// Register reads are combinational; irq/nmi follow the flag-setting edge by one cycle.
// Never stalls the bus; accesses with ready=0 have no side effects while counting continues.
module cpu_timer_irq
    import cpu_timer_irq_pkg::*;
#(
    parameter logic [15:0] RESET_LATCH = RESET_LATCH_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    cpu_timer_irq_if.slave  bus,
    input  logic            tick,
    output logic            irq,
    output logic            nmi
);

    localparam int IDX_W = $clog2(NUM_REGS);

    reg_idx_t    idx;
    logic        wr;
    logic        rd;
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
    logic [7:0]  ctrl_a;
    logic [7:0]  ctrl_b;
    logic        uf_a;
    logic        uf_b;
    logic        step_b;
    logic [1:0]  flags;
    logic [1:0]  mask;
    logic [1:0]  route;
    logic        pending;
    logic [7:0]  rd_data;
    logic        unused_addr_hi;

    assign idx            = reg_idx_t'(bus.timer_addr[IDX_W-1:0]);
    assign unused_addr_hi = ^bus.timer_addr[3:IDX_W];
    assign wr             = bus.timer_cs &  bus.cpu_write & bus.ready;
    assign rd             = bus.timer_cs & ~bus.cpu_write & bus.ready;

    assign step_b = ctrl_b[CTRL_CASCADE] ? uf_a : tick;

    cpu_timer_irq_timer16_unit #(.RESET_LATCH(RESET_LATCH)) u_timer_a (
        .clk       (clk),
        .reset     (reset),
        .wr_lo     (wr && idx == REG_TA_LO),
        .wr_hi     (wr && idx == REG_TA_HI),
        .wr_ctrl   (wr && idx == REG_CTRL_A),
        .wr_data   (bus.timer_data_i),
        .step      (tick),
        .count     (cnt_a),
        .ctrl      (ctrl_a),
        .underflow (uf_a)
    );

    cpu_timer_irq_timer16_unit #(.RESET_LATCH(RESET_LATCH)) u_timer_b (
        .clk       (clk),
        .reset     (reset),
        .wr_lo     (wr && idx == REG_TB_LO),
        .wr_hi     (wr && idx == REG_TB_HI),
        .wr_ctrl   (wr && idx == REG_CTRL_B),
        .wr_data   (bus.timer_data_i),
        .step      (step_b),
        .count     (cnt_b),
        .ctrl      (ctrl_b),
        .underflow (uf_b)
    );

    assign route   = {ctrl_b[CTRL_NMI_ROUTE], ctrl_a[CTRL_NMI_ROUTE]};
    assign pending = |(flags & mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 2'b00;
            mask  <= 2'b00;
            irq   <= 1'b0;
            nmi   <= 1'b0;
        end else begin
            // A fresh underflow survives the clear-on-read in the same edge.
            flags <= ((rd && idx == REG_ICR) ? 2'b00 : flags) | {uf_b, uf_a};
            if (wr && idx == REG_ICR)
                mask <= bus.timer_data_i[ICR_SET] ? (mask | bus.timer_data_i[1:0])
                                                  : (mask & ~bus.timer_data_i[1:0]);
            irq <= |(flags & mask & ~route);
            nmi <= |(flags & mask & route);
        end
    end

    always_comb begin
        rd_data = 8'h00;
        if (bus.timer_cs) begin
            case (idx)
                REG_TA_LO:  rd_data = cnt_a[7:0];
                REG_TA_HI:  rd_data = cnt_a[15:8];
                REG_TB_LO:  rd_data = cnt_b[7:0];
                REG_TB_HI:  rd_data = cnt_b[15:8];
                REG_CTRL_A: rd_data = ctrl_a;
                REG_CTRL_B: rd_data = ctrl_b;
                REG_ICR:    rd_data = icr_pack(pending, flags);
                default:    rd_data = 8'h00;
            endcase
        end
    end

    assign bus.timer_data_o = rd_data;

endmodule

// File: doc/cpu_timer_irq.md
Name: cpu_timer_irq

Overview:
- Memory-mapped dual 16-bit interval timer: the interrupt source placed directly upstream of cpu4510's irq/nmi inputs.
- Replaces the bench's io_port-bit interrupt stub.
- Decoded by the top level with a chip select, exactly like hyper_ctrl: shares cpu_address low bits, cpu_data_out_reg, cpu_write_reg and ready.
- Read data is muxed into cpu_data_in by the top level.

Parameters:
- RESET_LATCH, 16'hFFFF, reset value of both timer latches and counters.
- NUM_REGS, 8, decoded register count; addr[2:0] used, upper addr bits ignored.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- timer_cs  input  1  chip select from the top-level address decode.
- timer_addr  input  4  register index (cpu_address[3:0]).
- timer_data_i  input  8  write data (cpu data_o).
- timer_data_o  output  8  read data; combinational from timer_addr; 8'h00 when timer_cs=0.
- cpu_write  input  1  registered CPU write strobe.
- ready  input  1  bus ready; an access counts only when ready=1.
- tick  input  1  count enable / prescaler pulse; timers decrement only on tick=1 cycles.
- irq  output  1  level, active-high, to cpu4510 irq.
- nmi  output  1  level, active-high, to cpu4510 nmi.

Behaviour:
- Access qualifiers: wr = timer_cs & cpu_write & ready; rd = timer_cs & ~cpu_write & ready. Side effects happen on the clk edge.
- Register map (addr[2:0]):
  - 0 TA_LO, 1 TA_HI: reads return the counter; writes go to the latch.
  - 2 TB_LO, 3 TB_HI: same as timer A.
  - 4 CTRL_A, 5 CTRL_B.
  - 6 ICR.
  - 7 reads 8'h00; writes ignored.
- CTRL bits:
  - b0 START (run).
  - b1 ONESHOT.
  - b4 FORCE_LOAD: strobe; counter <= latch; reads back 0.
  - b5 (CTRL_B only) CASCADE: timer B decrements on timer A underflow instead of tick.
  - b6 NMI_ROUTE: the underflow flag drives nmi instead of irq.
  - Other bits are stored and read back unchanged.
- Writing a *_HI latch while that timer's START=0 also loads counter <= {new hi, latch lo} in the same edge.
- Count step (timer running, and tick=1, or cascade event for B):
  - counter==0: underflow. Set flag, counter <= latch; if ONESHOT, START <= 0.
  - otherwise counter <= counter-1.
  - The latch reads the pre-edge value: a latch write coinciding with an underflow reload affects the next reload only.
- Timer A underflow and a cascaded timer B step occur in the same cycle (no added latency).
- ICR read: {pending, 5'b0, flagB, flagA}, where pending = |(flags & mask).
  - The edge after an ICR read clears both flags.
  - An underflow in the same cycle as the ICR-read clear keeps its flag set: a new event wins.
- ICR write: bit7=1 sets the mask bits selected by b1:b0; bit7=0 clears them. Flags are unaffected.
- irq = |(flags & mask & ~route). nmi = |(flags & mask & route). Both are registered: they assert one cycle after the flag-setting edge and stay high until flags are cleared or masked.
- FORCE_LOAD together with a count step in the same write: the load wins, with no decrement.
- Reset, with priority over everything, sets:
  - latches and counters to RESET_LATCH;
  - CTRL, mask and flags to 0;
  - irq=0, nmi=0.
  - A reset mid-count discards all state; no interrupt is emitted.
- ready=0 suppresses all register side effects. Counting continues on tick regardless of ready.

Decomposition:
- Shared package holds:
  - register index constants (TA_LO…ICR);
  - CTRL bit positions;
  - ICR bit positions;
  - RESET_LATCH default.
- One natural sub-module: timer16_unit, one instance per timer. It holds latch, counter, ctrl, step input and underflow output. The top level adds cascade wiring, the ICR/mask and the interrupt outputs.

Test Plan:
- Reset → irq=0, nmi=0; TA_LO/TA_HI read FF/FF; ICR reads 00.
- Write TA_LO=03, TA_HI=00, ICR=81, CTRL_A=01, tick=1 constantly:
  - counter reads 3,2,1,0;
  - underflow on the 4th tick edge, then reload to 3;
  - irq=1 one cycle later;
  - ICR read returns 81;
  - irq=0 one cycle after the read.
- ONESHOT: CTRL_A=03 with latch 0002 → exactly one underflow, CTRL_A reads 02 afterward, counter reads 0002 and holds.
- Cascade: latch A=0001, B=0002, CTRL_B=21, CTRL_A=01, ICR=82 → B underflows on A's third underflow; flagB=1, flagA stays masked; irq=1.
- NMI route: CTRL_A=41 with mask A set → nmi=1, irq=0 on underflow; ICR read clears nmi.
- ICR read in the same cycle as an underflow → read returns old flags, and the new flag remains set afterward. Separately: a write with ready=0 leaves the latch unchanged.
